// File: rtl/masked_case_match.sv
// Two-stage registered case-style matcher: key = in_a & in_b is compared against a
// programmable label/result table; lowest enabled matching index wins.
module masked_case_match #(
  parameter int WIDTH        = 3,
  parameter int RES_W        = 3,
  parameter int ENTRIES      = 4,
  parameter int HOLD_ON_MISS = 1,
  parameter int DEFAULT_RES  = 0,
  parameter int CNT_W        = 8,
  localparam int IDX_W       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_label,
  input  logic [RES_W-1:0] cfg_res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [RES_W-1:0] out_result,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  input  logic             clr_cnt
);

  localparam logic [RES_W-1:0] DEF_RES = RES_W'(DEFAULT_RES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [ENTRIES-1:0] en_q;
  logic [WIDTH-1:0]   label_q [ENTRIES];
  logic [RES_W-1:0]   res_q   [ENTRIES];

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   key_q, key_d;
  logic               out_valid_q, out_valid_d;
  logic               out_hit_q, out_hit_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic               match_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [RES_W-1:0]   win_res_s;

  // Priority search: scanning from the top down lets the lowest matching index win.
  always_comb begin
    match_s   = 1'b0;
    win_idx_s = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (en_q[i] && (label_q[i] == key_q)) begin
        match_s   = 1'b1;
        win_idx_s = IDX_W'(i);
      end else begin
        match_s   = match_s;
      end
    end
    win_res_s = res_q[win_idx_s];
  end

  // Next-state for the sample pipeline, sticky outputs and statistics.
  always_comb begin
    s1_valid_d   = in_valid;
    key_d        = in_valid ? (in_a & in_b) : key_q;
    out_valid_d  = s1_valid_q;
    out_hit_d    = 1'b0;
    out_idx_d    = out_idx_q;
    out_result_d = out_result_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (s1_valid_q) begin
      if (match_s) begin
        out_hit_d    = 1'b1;
        out_idx_d    = win_idx_s;
        out_result_d = win_res_s;
        hit_cnt_d    = sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_d = sat_inc(miss_cnt_q);
        if (HOLD_ON_MISS == 0) begin
          out_result_d = DEF_RES;
        end else begin
          out_result_d = out_result_q;
        end
      end
    end else begin
      out_hit_d = 1'b0;
    end
    if (clr_cnt) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      hit_cnt_d  = hit_cnt_d;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      key_q        <= '0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_idx_q    <= '0;
      out_result_q <= DEF_RES;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      key_q        <= key_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_idx_q    <= out_idx_d;
      out_result_q <= out_result_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Table storage; an out-of-range index matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        label_q[i] <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          en_q[i]    <= cfg_en;
          label_q[i] <= cfg_label;
          res_q[i]   <= cfg_res;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_idx    = out_idx_q;
  assign out_result = out_result_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_masked_case_match.sv
// Directed bench: one instance holds on miss, the other loads DEFAULT_RES=5.
module tb_masked_case_match;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, cfg_en, in_valid, clr_cnt;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_label, cfg_res, in_a, in_b;

  logic       h_valid, h_hit, d_valid, d_hit;
  logic [1:0] h_idx, d_idx;
  logic [2:0] h_res, d_res;
  logic [7:0] h_hc, h_mc, d_hc, d_mc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_case_match #(.HOLD_ON_MISS(1), .DEFAULT_RES(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_label(cfg_label), .cfg_res(cfg_res), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(h_valid), .out_hit(h_hit), .out_idx(h_idx), .out_result(h_res),
    .hit_cnt(h_hc), .miss_cnt(h_mc), .clr_cnt(clr_cnt));

  masked_case_match #(.HOLD_ON_MISS(0), .DEFAULT_RES(5)) u_def (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_label(cfg_label), .cfg_res(cfg_res), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(d_valid), .out_hit(d_hit), .out_idx(d_idx), .out_result(d_res),
    .hit_cnt(d_hc), .miss_cnt(d_mc), .clr_cnt(clr_cnt));

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic en,
                             input logic [2:0] lab, input logic [2:0] res);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_label = lab; cfg_res = res;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Accept one sample, then wait until its result is on the outputs.
  task automatic send(input logic [2:0] a, input logic [2:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", h_valid); end
    checks++; if (h_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %0b expected 0", h_hit); end
    checks++; if (h_idx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", h_idx); end
    checks++; if (h_res !== 3'd0) begin errors++; $display("FAIL rst_res_hold: got %0d expected 0", h_res); end
    checks++; if (d_res !== 3'd5) begin errors++; $display("FAIL rst_res_def: got %0d expected 5", d_res); end
    checks++; if ({h_hc, h_mc} !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", h_hc, h_mc); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    write_entry(2'd0, 1'b1, 3'b000, 3'd0);
    write_entry(2'd1, 1'b1, 3'b001, 3'd1);
    write_entry(2'd2, 1'b1, 3'b010, 3'd2);
    send(3'b000, 3'b000);
    checks++; if (h_valid !== 1'b1) begin errors++; $display("FAIL s0_valid: got %0b expected 1", h_valid); end
    checks++; if (h_hit !== 1'b1) begin errors++; $display("FAIL s0_hit: got %0b expected 1", h_hit); end
    checks++; if (h_idx !== 2'd0) begin errors++; $display("FAIL s0_idx: got %0d expected 0", h_idx); end
    checks++; if (h_res !== 3'd0) begin errors++; $display("FAIL s0_res: got %0d expected 0", h_res); end
    send(3'b001, 3'b011);
    checks++; if (h_res !== 3'd1) begin errors++; $display("FAIL s1_res: got %0d expected 1", h_res); end
    checks++; if (h_idx !== 2'd1) begin errors++; $display("FAIL s1_idx: got %0d expected 1", h_idx); end
    send(3'b111, 3'b011);
    checks++; if (h_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %0b expected 1", h_valid); end
    checks++; if (h_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %0b expected 0", h_hit); end
    checks++; if (h_res !== 3'd1) begin errors++; $display("FAIL miss_res_hold: got %0d expected 1", h_res); end
    checks++; if (h_idx !== 2'd1) begin errors++; $display("FAIL miss_idx_hold: got %0d expected 1", h_idx); end
    checks++; if (h_mc !== 8'd1) begin errors++; $display("FAIL miss_cnt: got %0d expected 1", h_mc); end
    checks++; if (h_hc !== 8'd2) begin errors++; $display("FAIL hit_cnt: got %0d expected 2", h_hc); end
    checks++; if (d_res !== 3'd5) begin errors++; $display("FAIL miss_res_def: got %0d expected 5", d_res); end
    checks++; if (d_idx !== 2'd1) begin errors++; $display("FAIL miss_idx_def: got %0d expected 1", d_idx); end
    cyc();
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b expected 0", h_valid); end
    checks++; if (d_res !== 3'd5) begin errors++; $display("FAIL idle_res_def: got %0d expected 5", d_res); end
  endtask

  task automatic test_duplicate();
    write_entry(2'd1, 1'b1, 3'b100, 3'd6);
    write_entry(2'd3, 1'b1, 3'b100, 3'd7);
    send(3'b100, 3'b111);
    checks++; if (h_res !== 3'd6) begin errors++; $display("FAIL dup_res: got %0d expected 6", h_res); end
    checks++; if (h_idx !== 2'd1) begin errors++; $display("FAIL dup_idx: got %0d expected 1", h_idx); end
    write_entry(2'd1, 1'b0, 3'b100, 3'd6);
    send(3'b100, 3'b110);
    checks++; if (h_res !== 3'd7) begin errors++; $display("FAIL dis_res: got %0d expected 7", h_res); end
    checks++; if (h_idx !== 2'd3) begin errors++; $display("FAIL dis_idx: got %0d expected 3", h_idx); end
    write_entry(2'd1, 1'b1, 3'b100, 3'd6);
    // Disable write lands on the same edge the key is compared in S2.
    in_valid = 1'b1; in_a = 3'b100; in_b = 3'b100;
    cyc();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b0; cfg_label = 3'b100; cfg_res = 3'd6;
    cyc();
    cfg_we = 1'b0;
    checks++; if (h_res !== 3'd6) begin errors++; $display("FAIL coll_res: got %0d expected 6", h_res); end
    checks++; if (h_idx !== 2'd1) begin errors++; $display("FAIL coll_idx: got %0d expected 1", h_idx); end
    send(3'b100, 3'b100);
    checks++; if (h_res !== 3'd7) begin errors++; $display("FAIL post_coll_res: got %0d expected 7", h_res); end
    checks++; if (h_hc !== 8'd6) begin errors++; $display("FAIL dup_hit_cnt: got %0d expected 6", h_hc); end
  endtask

  task automatic test_back_to_back();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    checks++; if ({h_hc, h_mc} !== 16'd0) begin errors++; $display("FAIL clr: got %0d/%0d expected 0/0", h_hc, h_mc); end
    in_valid = 1'b1; in_a = 3'b000; in_b = 3'b101;
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (h_hc !== 8'd9) begin errors++; $display("FAIL stream_cnt: got %0d expected 9", h_hc); end
    checks++; if (h_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %0b expected 1", h_valid); end
    for (int i = 0; i < 290; i++) cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    checks++; if (h_hc !== 8'd255) begin errors++; $display("FAIL sat_hit: got %0d expected 255", h_hc); end
    checks++; if (d_hc !== 8'd255) begin errors++; $display("FAIL sat_hit_def: got %0d expected 255", d_hc); end
    checks++; if (h_mc !== 8'd0) begin errors++; $display("FAIL sat_miss: got %0d expected 0", h_mc); end
    in_valid = 1'b1; in_a = 3'b000; in_b = 3'b000;
    cyc();
    in_valid = 1'b0; clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    checks++; if (h_valid !== 1'b1) begin errors++; $display("FAIL clrhit_valid: got %0b expected 1", h_valid); end
    checks++; if (h_hc !== 8'd0) begin errors++; $display("FAIL clrhit_cnt: got %0d expected 0", h_hc); end
    send(3'b111, 3'b011);
    checks++; if ({h_hc, h_mc} !== {8'd0, 8'd1}) begin errors++; $display("FAIL post_clr: got %0d/%0d expected 0/1", h_hc, h_mc); end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_a = 3'b010; in_b = 3'b010;
    cyc();
    in_a = 3'b010; in_b = 3'b011;
    cyc();
    checks++; if (h_res !== 3'd2) begin errors++; $display("FAIL pre_rst_res: got %0d expected 2", h_res); end
    #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (h_res !== 3'd0) begin errors++; $display("FAIL mrst_res_hold: got %0d expected 0", h_res); end
    checks++; if (d_res !== 3'd5) begin errors++; $display("FAIL mrst_res_def: got %0d expected 5", d_res); end
    checks++; if ({h_valid, h_hit, h_idx} !== 4'd0) begin errors++; $display("FAIL mrst_ctl: got %0h expected 0", {h_valid, h_hit, h_idx}); end
    checks++; if ({h_hc, h_mc} !== 16'd0) begin errors++; $display("FAIL mrst_cnt: got %0d/%0d expected 0/0", h_hc, h_mc); end
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid%0d: got %0b expected 0", i, h_valid); end
    end
    send(3'b010, 3'b010);
    checks++; if (h_hit !== 1'b0) begin errors++; $display("FAIL empty_hit: got %0b expected 0", h_hit); end
    checks++; if (h_mc !== 8'd1) begin errors++; $display("FAIL empty_miss: got %0d expected 1", h_mc); end
    checks++; if (h_res !== 3'd0) begin errors++; $display("FAIL empty_res: got %0d expected 0", h_res); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_label = 3'd0; cfg_res = 3'd0;
    in_valid = 1'b0; in_a = 3'd0; in_b = 3'd0; clr_cnt = 1'b0;
    test_reset();
    test_basic();
    test_duplicate();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
